// File: rtl/lcd_pkg.sv
// Shared types and constants for the lcd_char_stream HD44780 4-bit driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_NIB,
    INIT_BYTE,
    IDLE,
    TX_HI,
    TX_LO,
    WAIT
  } lcd_state_e;

  typedef enum logic [2:0] {
    T_IDLE,
    T_SETUP,
    T_PULSE,
    T_HOLD,
    T_WAIT
  } nib_phase_e;

  localparam logic [7:0] CMD_FUNC_4BIT_2LINE = 8'h28;
  localparam logic [7:0] CMD_DISP_ON         = 8'h0C;
  localparam logic [7:0] CMD_CLEAR           = 8'h01;
  localparam logic [7:0] CMD_ENTRY_INC       = 8'h06;
  localparam logic [7:0] CMD_DDRAM_ROW0      = 8'h80;
  localparam logic [7:0] CMD_DDRAM_ROW1      = 8'hC0;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  // Clear and home commands need the long busy time.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = CMD_FUNC_4BIT_2LINE;
      2'd1:    b = CMD_DISP_ON;
      2'd2:    b = CMD_CLEAR;
      default: b = CMD_ENTRY_INC;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/lcd_nibble_tx.sv
// Nibble sequencer (SETUP/PULSE/HOLD) plus plain timed waits, sharing one
// down-counter; owns the registered lcd_e/lcd_rs/lcd_d pins.
module lcd_nibble_tx
  import lcd_pkg::*;
#(
  parameter int unsigned E_HIGH_CYC     = 50,
  parameter int unsigned NIBBLE_GAP_CYC = 100,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             send,
  input  logic [3:0]       nib,
  input  logic             rs,
  input  logic [CNT_W-1:0] wait_cyc,
  output logic             ready,
  output logic             lcd_e,
  output logic             lcd_rs,
  output logic [3:0]       lcd_d
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(NIBBLE_GAP_CYC - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  nib_phase_e       phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [3:0]       d_q, d_d;
  logic             last;

  // ready is also high in the final cycle of a sequence so the next command
  // starts without a bubble cycle.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    e_d     = e_q;
    rs_d    = rs_q;
    d_d     = d_q;
    last    = (cnt_q == '0);
    ready   = (phase_q == T_IDLE) || (last && (phase_q == T_HOLD || phase_q == T_WAIT));

    case (phase_q)
      T_SETUP: begin
        phase_d = T_PULSE;
        cnt_d   = PULSE_LD;
        e_d     = 1'b1;
      end
      T_PULSE: begin
        if (last) begin
          phase_d = T_HOLD;
          cnt_d   = HOLD_LD;
          e_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      T_HOLD, T_WAIT: begin
        if (last) phase_d = T_IDLE;
        else      cnt_d   = cnt_q - ONE;
      end
      default: ;
    endcase

    if (start && ready) begin
      if (send) begin
        phase_d = T_SETUP;
        cnt_d   = '0;
        rs_d    = rs;
        d_d     = nib;
      end else begin
        phase_d = T_WAIT;
        cnt_d   = wait_cyc - ONE;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase_q <= T_IDLE;
      cnt_q   <= '0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      d_q     <= d_d;
    end
  end

  assign lcd_e  = e_q;
  assign lcd_rs = rs_q;
  assign lcd_d  = d_q;

endmodule

// File: rtl/lcd_char_stream.sv
// HD44780 4-bit character stream driver: autonomous power-on init, then
// valid/ready byte transfer. Define LCD_LINE_WRAP_EN for 16x2 cursor wrap.
module lcd_char_stream
  import lcd_pkg::*;
#(
  parameter int unsigned E_HIGH_CYC     = 50,
  parameter int unsigned NIBBLE_GAP_CYC = 100,
  parameter int unsigned CMD_WAIT_CYC   = 5000,
  parameter int unsigned LONG_WAIT_CYC  = 164000,
  parameter int unsigned POWERUP_CYC    = 1500000,
  parameter int unsigned INIT_WAIT_CYC  = 410000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_e,
  output logic [3:0] lcd_d
);

  localparam int unsigned MAX_A   = (POWERUP_CYC > LONG_WAIT_CYC) ? POWERUP_CYC : LONG_WAIT_CYC;
  localparam int unsigned MAX_B   = (INIT_WAIT_CYC > 2 * CMD_WAIT_CYC) ? INIT_WAIT_CYC : 2 * CMD_WAIT_CYC;
  localparam int unsigned MAX_C   = (E_HIGH_CYC > NIBBLE_GAP_CYC) ? E_HIGH_CYC : NIBBLE_GAP_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] W_PWRUP = CNT_W'(POWERUP_CYC);
  localparam logic [CNT_W-1:0] W_INIT  = CNT_W'(INIT_WAIT_CYC);
  localparam logic [CNT_W-1:0] W_CMD   = CNT_W'(CMD_WAIT_CYC);
  localparam logic [CNT_W-1:0] W_CMD2  = CNT_W'(2 * CMD_WAIT_CYC);
  localparam logic [CNT_W-1:0] W_LONG  = CNT_W'(LONG_WAIT_CYC);

  lcd_state_e       state_q, state_d;
  logic [1:0]       sub_q, sub_d;
  logic [1:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             rs_q, rs_d;
  logic             init_done_q, init_done_d;

  logic             tx_start, tx_send, tx_rs, tx_ready;
  logic [3:0]       tx_nib;
  logic [CNT_W-1:0] tx_wait, nib_wait, byte_wait;

`ifdef LCD_LINE_WRAP_EN
  logic [3:0] col_q, col_d;
  logic       row_q, row_d;
  logic       wrap_q, wrap_d;
`endif

  always_comb begin
    case (idx_q)
      2'd0:    nib_wait = W_INIT;
      2'd1:    nib_wait = W_CMD2;
      default: nib_wait = W_CMD;
    endcase
    byte_wait = is_long_cmd(rs_q, byte_q) ? W_LONG : W_CMD;
  end

  // sub_q tracks which command is currently in flight within a state:
  // 0 = first nibble, 1 = second nibble or post-nibble wait, 2 = post-byte wait.
  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    init_done_d = init_done_q;
    tx_start    = 1'b0;
    tx_send     = 1'b1;
    tx_nib      = byte_q[3:0];
    tx_rs       = rs_q;
    tx_wait     = W_CMD;
`ifdef LCD_LINE_WRAP_EN
    col_d       = col_q;
    row_d       = row_q;
    wrap_d      = wrap_q;
`endif

    case (state_q)
      PWRUP: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          if (sub_q == 2'd0) begin
            tx_send = 1'b0;
            tx_wait = W_PWRUP;
            sub_d   = 2'd1;
          end else begin
            tx_nib  = INIT_NIB_8BIT;
            tx_rs   = 1'b0;
            state_d = INIT_NIB;
            idx_d   = 2'd0;
            sub_d   = 2'd0;
          end
        end
      end
      INIT_NIB: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          tx_rs    = 1'b0;
          if (sub_q == 2'd0) begin
            tx_send = 1'b0;
            tx_wait = nib_wait;
            sub_d   = 2'd1;
          end else if (idx_q != 2'd3) begin
            tx_nib = (idx_q == 2'd2) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
            idx_d  = idx_q + 2'd1;
            sub_d  = 2'd0;
          end else begin
            byte_d  = init_byte(2'd0);
            rs_d    = 1'b0;
            tx_nib  = byte_d[7:4];
            state_d = INIT_BYTE;
            idx_d   = 2'd0;
            sub_d   = 2'd0;
          end
        end
      end
      INIT_BYTE: begin
        if (tx_ready) begin
          if (sub_q == 2'd0) begin
            tx_start = 1'b1;
            sub_d    = 2'd1;
          end else if (sub_q == 2'd1) begin
            tx_start = 1'b1;
            tx_send  = 1'b0;
            tx_wait  = byte_wait;
            sub_d    = 2'd2;
          end else if (idx_q == 2'd3) begin
            state_d     = IDLE;
            init_done_d = 1'b1;
            sub_d       = 2'd0;
          end else begin
            idx_d    = idx_q + 2'd1;
            byte_d   = init_byte(idx_q + 2'd1);
            tx_start = 1'b1;
            tx_nib   = byte_d[7:4];
            sub_d    = 2'd0;
          end
        end
      end
      IDLE: begin
        if (in_valid) begin
          byte_d   = in_data;
          rs_d     = in_rs;
          tx_start = 1'b1;
          tx_nib   = in_data[7:4];
          tx_rs    = in_rs;
          state_d  = TX_HI;
`ifdef LCD_LINE_WRAP_EN
          if (in_rs) begin
            if (col_q == 4'd15) begin
              col_d  = '0;
              row_d  = ~row_q;
              wrap_d = 1'b1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end else if (is_long_cmd(1'b0, in_data)) begin
            col_d = '0;
            row_d = 1'b0;
          end else if (in_data[7]) begin
            col_d = in_data[3:0];
            row_d = in_data[6];
          end
`endif
        end
      end
      TX_HI: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          state_d  = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          tx_send  = 1'b0;
          tx_wait  = byte_wait;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (tx_ready) begin
          state_d = IDLE;
`ifdef LCD_LINE_WRAP_EN
          // Row already toggled at accept time, so it selects the new line.
          if (wrap_q) begin
            wrap_d   = 1'b0;
            byte_d   = row_q ? CMD_DDRAM_ROW1 : CMD_DDRAM_ROW0;
            rs_d     = 1'b0;
            tx_start = 1'b1;
            tx_nib   = byte_d[7:4];
            tx_rs    = 1'b0;
            state_d  = TX_HI;
          end
`endif
        end
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= PWRUP;
      sub_q       <= '0;
      idx_q       <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef LCD_LINE_WRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      wrap_q <= wrap_d;
    end
  end
`endif

  lcd_nibble_tx #(
    .E_HIGH_CYC     (E_HIGH_CYC),
    .NIBBLE_GAP_CYC (NIBBLE_GAP_CYC),
    .CNT_W          (CNT_W)
  ) u_tx (
    .clock    (clock),
    .reset    (reset),
    .start    (tx_start),
    .send     (tx_send),
    .nib      (tx_nib),
    .rs       (tx_rs),
    .wait_cyc (tx_wait),
    .ready    (tx_ready),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_d    (lcd_d)
  );

  assign in_ready  = (state_q == IDLE);
  assign init_done = init_done_q;

endmodule

// File: doc/lcd_char_stream.md
Name: lcd_char_stream

Overview:
- Parametrised HD44780-style character LCD driver using the 4-bit bus interface.
- After reset it runs the full power-on initialisation autonomously, then accepts command or character bytes through a valid/ready handshake.
- Each byte is sent as two enable-strobed nibbles with programmable timing.
- Sits between game/UI logic (score text, prompts) and the board LCD pins.

Parameters:
- E_HIGH_CYC, 50, clock cycles lcd_e is held high per nibble.
- NIBBLE_GAP_CYC, 100, cycles lcd_e is low, with data held, after each pulse.
- CMD_WAIT_CYC, 5000, post-byte wait for ordinary commands and data.
- LONG_WAIT_CYC, 164000, post-byte wait for clear (0x01) and home (0x02/0x03).
- POWERUP_CYC, 1500000, idle wait after reset before the first init nibble.
- INIT_WAIT_CYC, 410000, wait after the first 0x3 init nibble.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  byte offered
- in_rs  in  1  0 = command, 1 = character data
- in_data  in  8  byte to send
- in_ready  out  1  block can accept a byte this cycle
- init_done  out  1  power-on sequence complete
- lcd_rs  out  1  LCD register select
- lcd_e  out  1  LCD enable strobe
- lcd_d  out  4  LCD data bus bits [7:4]

Behaviour:
- Reset values:
  - lcd_e=0, lcd_rs=0, lcd_d=0, in_ready=0, init_done=0.
  - All counters and FSM state are cleared asynchronously.
- Nibble transmit, fixed three-phase sequence:
  - SETUP: 1 cycle; lcd_rs/lcd_d valid, lcd_e=0.
  - PULSE: E_HIGH_CYC cycles with lcd_e=1.
  - HOLD: NIBBLE_GAP_CYC cycles with lcd_e=0.
  - lcd_rs and lcd_d are stable throughout all three phases.
- Byte transmit:
  - High nibble (data[7:4]) first, then low nibble, both with the same rs.
  - Then WAIT: LONG_WAIT_CYC if rs=0 and data is in {0x01,0x02,0x03}, else CMD_WAIT_CYC.
- FSM states: PWRUP, INIT_NIB, INIT_BYTE, IDLE, TX_HI, TX_LO, WAIT.
- Init sequence, all with rs=0:
  - PWRUP: wait POWERUP_CYC.
  - Single nibble 0x3, wait INIT_WAIT_CYC.
  - Nibble 0x3, wait 2*CMD_WAIT_CYC.
  - Nibble 0x3, wait CMD_WAIT_CYC.
  - Nibble 0x2, wait CMD_WAIT_CYC.
  - Full bytes 0x28, 0x0C, 0x01, 0x06, with the standard waits.
  - init_done rises the cycle IDLE is first entered and stays high until reset.
- Handshake:
  - in_ready=1 only in IDLE.
  - Transfer occurs on a rising clock edge with in_valid & in_ready.
  - in_rs and in_data are captured at that edge.
  - in_ready=0 from the next cycle until the byte's WAIT completes.
  - Inputs are ignored whenever in_ready=0, including during init.
- Latency: a non-long byte accepted at cycle t makes in_ready return at t+1+2*(1+E_HIGH_CYC+NIBBLE_GAP_CYC)+CMD_WAIT_CYC.
- Counter: a single down-counter, width sized from the largest parameter; it reloads on every phase entry.
- Reset mid-operation: lcd_e drops immediately, with no glitch completion. The full init sequence replays after release.

Optional Feature:
- Macro: LCD_LINE_WRAP_EN (16x2 cursor tracking).
- When defined:
  - The block tracks col (0..15) and row (0..1).
  - Each rs=1 byte increments col.
  - After a character written at col 15, an automatic command is emitted before in_ready returns: 0xC0 if moving to row 1, 0x80 if wrapping back to row 0. It uses normal nibble timing plus CMD_WAIT_CYC.
  - Commands 0x01/0x02/0x03 reset the position to (0,0).
  - A command with bit7=1 loads position from the address: 0x00–0x0F gives row 0, 0x40–0x4F gives row 1.
- When undefined: no tracking and no inserted commands.

Decomposition:
- Package lcd_pkg holds:
  - FSM state enum.
  - Command constants: CMD_FUNC_4BIT_2LINE=0x28, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_ENTRY_INC=0x06, CMD_DDRAM_ROW0=0x80, CMD_DDRAM_ROW1=0xC0.
  - Init nibble constants.
- Sub-module lcd_nibble_tx: the SETUP/PULSE/HOLD sequencer with start/done handshake, owning lcd_e/lcd_d/lcd_rs registers.

Test Plan (bench params E_HIGH_CYC=2, NIBBLE_GAP_CYC=3, CMD_WAIT_CYC=10, LONG_WAIT_CYC=40, POWERUP_CYC=50, INIT_WAIT_CYC=20):
- Reset release: no lcd_e activity for 50 cycles; then lcd_d at each rising lcd_e is 3,3,3,2,2,8,0,C,0,1,0,6 with rs=0 (12 pulses); init_done=1, in_ready=1 afterwards.
- Send rs=1, 0x41: nibbles 4 then 1 with lcd_rs=1; every pulse exactly 2 cycles high; in_ready low for exactly 22 cycles.
- Send rs=0, 0x01: post-byte wait 40 cycles; in_ready low for 52 cycles. Send 0x80: 22 cycles.
- in_valid held high with changing data: one transfer per ready window and no byte lost or duplicated; in_valid asserted during init produces no extra pulses.
- Assert reset while lcd_e=1: lcd_e=0 and init_done=0 in the same cycle, without waiting for a clock edge; after release the full 12-nibble init replays.
- LCD_LINE_WRAP_EN: 16 characters cause an automatic 0xC0 after the 16th; 32 characters cause 0x80 after the 32nd; a 0x01 mid-line restarts the count at column 0.
